// File: rtl/eff_clip_ms.sv
// -----------------------------------------------------------------------------
// eff_clip_ms
// Multi-mode clipping / distortion stage for the offset-binary audio byte path.
// Each sample gets a programmable pre-gain (stage 1), then one of four shaping
// modes against a programmable threshold (stage 2). The stages are joined by a
// valid/ready stream that has one global advance enable. A saturating counter
// counts the clipped samples that have been delivered.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   s_valid      input sample valid
//   s_ready      block can accept an input sample (combinational)
//   s_data       input sample, offset-binary
//   i_mode       00 bypass, 01 hard, 10 soft, 11 asymmetric
//   i_gain       unsigned pre-gain with FRAC_W fractional bits
//   i_thresh     unsigned clip threshold T
//   m_valid      output sample valid
//   m_ready      downstream accepts the output sample
//   m_data       output sample, offset-binary
//   o_clip_flag  current m_data sample was altered by clipping/saturation
//   o_clip_cnt   saturating count of delivered clipped samples
// -----------------------------------------------------------------------------
module eff_clip_ms #(
    parameter int DATA_W = 8,
    parameter int GAIN_W = 4,
    parameter int FRAC_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [1:0]        i_mode,
    input  logic [GAIN_W-1:0] i_gain,
    input  logic [DATA_W-2:0] i_thresh,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              o_clip_flag,
    output logic [CNT_W-1:0]  o_clip_cnt
);

    // The product width holds the full-scale input multiplied by the maximum gain.
    // The shaping width adds two more bits so that T +/- offsets and negation
    // cannot wrap before saturation.
    localparam int PW = DATA_W + GAIN_W + 1;
    localparam int ZW = PW + 2;

    localparam logic signed [ZW-1:0] SAT_HI  = ZW'((32'sd1 << (DATA_W - 1)) - 32'sd1);
    localparam logic signed [ZW-1:0] SAT_LO  = ~SAT_HI;
    localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]    MID     = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [ZW-1:0] clamp_f(
        input logic signed [ZW-1:0] v,
        input logic signed [ZW-1:0] lo,
        input logic signed [ZW-1:0] hi
    );
        logic signed [ZW-1:0] r;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic signed [ZW-1:0] sat_f(input logic signed [ZW-1:0] v);
        return clamp_f(v, SAT_LO, SAT_HI);
    endfunction

    // Stage 1 registers: gained sample plus the configuration captured with it
    logic              v1_q,    v1_d;
    logic [PW-1:0]     y1_q,    y1_d;
    logic [1:0]        mode1_q, mode1_d;
    logic [DATA_W-2:0] thr1_q,  thr1_d;

    // Stage 2 registers drive the output port directly
    logic              v2_q,    v2_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic              flag2_q, flag2_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic                     adv_s;
    logic signed [DATA_W-1:0] x_s;
    logic signed [PW-1:0]     x_ext_s;
    logic signed [PW-1:0]     g_ext_s;
    logic signed [PW-1:0]     p_s;
    logic signed [PW-1:0]     y_s;

    logic signed [ZW-1:0]     y_w_s;
    logic signed [ZW-1:0]     t_w_s;
    logic signed [ZW-1:0]     th_w_s;
    logic signed [ZW-1:0]     soft_hi_s;
    logic signed [ZW-1:0]     soft_lo_s;
    logic signed [ZW-1:0]     z_s;
    logic                     clip_s;

    // A stalled output blocks the whole pipe, so there is only one advance enable
    assign adv_s = !v2_q || m_ready;

    // Stage 1 datapath: convert offset-binary to signed, apply gain, drop fraction (floor)
    always_comb begin
        x_s     = {~s_data[DATA_W-1], s_data[DATA_W-2:0]};
        x_ext_s = {{(PW-DATA_W){x_s[DATA_W-1]}}, x_s};
        g_ext_s = {{(PW-GAIN_W){1'b0}}, i_gain};
        p_s     = x_ext_s * g_ext_s;
        y_s     = p_s >>> FRAC_W;
    end

    // Stage 2 datapath: apply the shaping mode that was captured with the sample
    always_comb begin
        y_w_s     = {{(ZW-PW){y1_q[PW-1]}}, y1_q};
        t_w_s     = {{(ZW-DATA_W+1){1'b0}}, thr1_q};
        th_w_s    = t_w_s >>> 2'd1;
        soft_hi_s = sat_f(t_w_s + ((y_w_s - t_w_s) >>> 2'd2));
        soft_lo_s = sat_f(-t_w_s - ((-y_w_s - t_w_s) >>> 2'd2));
        case (mode1_q)
            2'b00:   z_s = sat_f(y_w_s);
            2'b01:   z_s = clamp_f(y_w_s, -t_w_s, t_w_s);
            2'b10: begin
                if (y_w_s > t_w_s) begin
                    z_s = soft_hi_s;
                end else if (y_w_s < -t_w_s) begin
                    z_s = soft_lo_s;
                end else begin
                    z_s = y_w_s;
                end
            end
            2'b11:   z_s = clamp_f(y_w_s, -th_w_s, t_w_s);
            default: z_s = sat_f(y_w_s);
        endcase
        clip_s = (z_s != y_w_s);
    end

    // Next-state logic for both stages and the clip counter
    always_comb begin
        v1_d    = v1_q;
        y1_d    = y1_q;
        mode1_d = mode1_q;
        thr1_d  = thr1_q;
        v2_d    = v2_q;
        data2_d = data2_q;
        flag2_d = flag2_q;
        cnt_d   = cnt_q;

        if (adv_s) begin
            v1_d = s_valid;
            if (s_valid) begin
                y1_d    = y_s;
                mode1_d = i_mode;
                thr1_d  = i_thresh;
            end else begin
                y1_d    = y1_q;
            end

            v2_d = v1_q;
            // A bubble keeps the last data but must not advertise a clip
            if (v1_q) begin
                data2_d = {~z_s[DATA_W-1], z_s[DATA_W-2:0]};
                flag2_d = clip_s;
            end else begin
                flag2_d = 1'b0;
            end
        end else begin
            v1_d = v1_q;
        end

        // Counted on delivery only, so a stalled sample is counted exactly once
        if (v2_q && m_ready && flag2_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline and counter registers with synchronous flush
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q    <= 1'b0;
            y1_q    <= {PW{1'b0}};
            mode1_q <= 2'b00;
            thr1_q  <= {(DATA_W-1){1'b0}};
            v2_q    <= 1'b0;
            data2_q <= MID;
            flag2_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            v1_q    <= v1_d;
            y1_q    <= y1_d;
            mode1_q <= mode1_d;
            thr1_q  <= thr1_d;
            v2_q    <= v2_d;
            data2_q <= data2_d;
            flag2_q <= flag2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_ready     = adv_s;
    assign m_valid     = v2_q;
    assign m_data      = data2_q;
    assign o_clip_flag = flag2_q;
    assign o_clip_cnt  = cnt_q;

endmodule

// File: tb/tb_eff_clip_ms.sv
// -----------------------------------------------------------------------------
// tb_eff_clip_ms
// Directed bench for eff_clip_ms. Two instances share the same stimulus: u_dut
// uses the default 16-bit counter, and u_sat uses a 2-bit counter to exercise
// counter saturation. Expected values are computed by hand from the sample
// arithmetic.
// -----------------------------------------------------------------------------
module tb_eff_clip_ms;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [1:0] i_mode;
    logic [3:0] i_gain;
    logic [6:0] i_thresh;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       clip_flag;
    logic [15:0] clip_cnt;

    logic       u2_s_ready;
    logic       u2_m_valid;
    logic [7:0] u2_m_data;
    logic       u2_clip_flag;
    logic [1:0] u2_clip_cnt;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    eff_clip_ms u_dut (
        .i_clk(clk), .i_rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .i_mode(i_mode), .i_gain(i_gain), .i_thresh(i_thresh),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .o_clip_flag(clip_flag), .o_clip_cnt(clip_cnt)
    );

    eff_clip_ms #(.CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst(rst),
        .s_valid(s_valid), .s_ready(u2_s_ready), .s_data(s_data),
        .i_mode(i_mode), .i_gain(i_gain), .i_thresh(i_thresh),
        .m_valid(u2_m_valid), .m_ready(m_ready), .m_data(u2_m_data),
        .o_clip_flag(u2_clip_flag), .o_clip_cnt(u2_clip_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Sends one sample into an empty pipe with m_ready high. It checks the
    // 2-cycle latency, the data and the flag, and then the counters after delivery.
    // The configuration is changed straight after acceptance to show that it is captured.
    task automatic run(input string tag, input logic [1:0] mode, input logic [3:0] gain,
                       input logic [6:0] thr, input logic [7:0] din,
                       input logic [7:0] exp_d, input logic exp_f);
        s_valid  = 1'b1;
        s_data   = din;
        i_mode   = mode;
        i_gain   = gain;
        i_thresh = thr;
        check({tag, ".ready"}, 32'(s_ready), 32'd1);
        step();
        s_valid  = 1'b0;
        s_data   = ~din;
        i_mode   = ~mode;
        i_gain   = 4'd0;
        i_thresh = 7'd0;
        check({tag, ".early"}, 32'(m_valid), 32'd0);
        step();
        check({tag, ".valid"}, 32'(m_valid), 32'd1);
        check({tag, ".data"},  32'(m_data),  32'(exp_d));
        check({tag, ".flag"},  32'(clip_flag), 32'(exp_f));
        if (exp_f) begin
            exp_cnt++;
        end
        step();
        check({tag, ".drain"}, 32'(m_valid), 32'd0);
        check({tag, ".cnt"},   32'(clip_cnt), 32'(exp_cnt));
        check({tag, ".cnt2"},  32'(u2_clip_cnt), 32'(sat3(exp_cnt)));
    endtask

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        i_mode   = 2'b00;
        i_gain   = 4'd0;
        i_thresh = 7'd0;
        m_ready  = 1'b1;
        step();
        step();
        check("rst.valid", 32'(m_valid), 32'd0);
        check("rst.data",  32'(m_data),  32'h80);
        check("rst.flag",  32'(clip_flag), 32'd0);
        check("rst.cnt",   32'(clip_cnt), 32'd0);
        check("rst.cnt2",  32'(u2_clip_cnt), 32'd0);
        rst = 1'b0;
        step();
        check("rst.ready", 32'(s_ready), 32'd1);

        // Bypass at unity gain
        run("byp", 2'b00, 4'd4, 7'd0, 8'hF0, 8'hF0, 1'b0);
        // Hard clip at T=100
        run("hard_p", 2'b01, 4'd4, 7'd100, 8'hFF, 8'hE4, 1'b1);
        run("hard_n", 2'b01, 4'd4, 7'd100, 8'h00, 8'h1C, 1'b1);
        run("hard_i", 2'b01, 4'd4, 7'd100, 8'hA0, 8'hA0, 1'b0);
        check("hard.cnt", 32'(clip_cnt), 32'd2);
        // Soft knee at T=64: +/-112 -> +/-76
        run("soft_p", 2'b10, 4'd4, 7'd64, 8'hF0, 8'hCC, 1'b1);
        run("soft_n", 2'b10, 4'd4, 7'd64, 8'h10, 8'h34, 1'b1);
        // Bypass with gain 3.0 saturates +/-150
        run("sat_p", 2'b00, 4'd12, 7'd0, 8'hB2, 8'hFF, 1'b1);
        run("sat_n", 2'b00, 4'd12, 7'd0, 8'h4E, 8'h00, 1'b1);
        // Asymmetric at T=80: +112 -> 80, -112 -> -40
        run("asym_p", 2'b11, 4'd4, 7'd80, 8'hF0, 8'hD0, 1'b1);
        run("asym_n", 2'b11, 4'd4, 7'd80, 8'h10, 8'h58, 1'b1);
        // Boundaries: zero gain, zero threshold, maximum gain, floor rounding
        run("gain0",  2'b01, 4'd0,  7'd10, 8'hFF, 8'h80, 1'b0);
        run("t0",     2'b01, 4'd4,  7'd0,  8'hC0, 8'h80, 1'b1);
        run("gmax_n", 2'b00, 4'd15, 7'd0,  8'h00, 8'h00, 1'b1);
        run("gmax_p", 2'b00, 4'd15, 7'd0,  8'hFF, 8'hFF, 1'b1);
        run("floor",  2'b00, 4'd5,  7'd0,  8'h7F, 8'h7E, 1'b0);

        // Backpressure: three back-to-back samples while m_ready is held low
        m_ready  = 1'b0;
        i_mode   = 2'b01;
        i_gain   = 4'd4;
        i_thresh = 7'd100;
        s_valid  = 1'b1;
        s_data   = 8'hFF;
        step();
        s_data = 8'hA0;
        check("bp.ready1", 32'(s_ready), 32'd1);
        step();
        s_data = 8'h00;
        check("bp.ready2", 32'(s_ready), 32'd0);
        check("bp.valid",  32'(m_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.stall_ready", 32'(s_ready), 32'd0);
            check("bp.stall_data",  32'(m_data),  32'hE4);
            check("bp.stall_flag",  32'(clip_flag), 32'd1);
            check("bp.stall_cnt",   32'(clip_cnt), 32'(exp_cnt));
        end
        m_ready = 1'b1;
        #1;
        check("bp.release", 32'(s_ready), 32'd1);
        step();
        exp_cnt++;
        s_valid = 1'b0;
        check("bp.b_data", 32'(m_data), 32'hA0);
        check("bp.b_flag", 32'(clip_flag), 32'd0);
        check("bp.a_cnt",  32'(clip_cnt), 32'(exp_cnt));
        step();
        check("bp.c_valid", 32'(m_valid), 32'd1);
        check("bp.c_data",  32'(m_data), 32'h1C);
        check("bp.c_flag",  32'(clip_flag), 32'd1);
        step();
        exp_cnt++;
        check("bp.nodup", 32'(m_valid), 32'd0);
        check("bp.cnt",   32'(clip_cnt), 32'(exp_cnt));

        // Reset with two clipped samples in flight
        s_valid = 1'b1;
        s_data  = 8'hFF;
        step();
        s_data = 8'h00;
        step();
        s_valid = 1'b0;
        rst     = 1'b1;
        step();
        rst     = 1'b0;
        exp_cnt = 0;
        check("flush.valid", 32'(m_valid), 32'd0);
        check("flush.data",  32'(m_data), 32'h80);
        check("flush.cnt",   32'(clip_cnt), 32'd0);
        check("flush.cnt2",  32'(u2_clip_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("flush.gone", 32'(m_valid), 32'd0);
        end

        // Five clipped samples: the 2-bit counter sticks at 3
        for (int i = 0; i < 5; i++) begin
            run("cntsat", 2'b01, 4'd4, 7'd100, 8'hFF, 8'hE4, 1'b1);
        end
        check("cntsat.final", 32'(u2_clip_cnt), 32'd3);
        check("cntsat.wide",  32'(clip_cnt), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
